// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS control unit: the FSM state type,
// ALU operation codes, instruction opcode/funct constants and datapath select
// encodings.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        StFetch  = 4'd0,
        StDecode = 4'd1,
        StExec   = 4'd2,
        StMemRd  = 4'd3,
        StMemWr  = 4'd4,
        StWbMem  = 4'd5,
        StWbAlu  = 4'd6,
        StBranch = 4'd7,
        StJump   = 4'd8,
        StTrap   = 4'd9
    } state_t;

    // ALU operation codes
    localparam logic [5:0] OP_ADD  = 6'b100000;
    localparam logic [5:0] OP_ADDU = 6'b100001;
    localparam logic [5:0] OP_SUB  = 6'b100010;
    localparam logic [5:0] OP_SUBU = 6'b100011;
    localparam logic [5:0] OP_AND  = 6'b100100;
    localparam logic [5:0] OP_OR   = 6'b100101;
    localparam logic [5:0] OP_XOR  = 6'b100110;
    localparam logic [5:0] OP_NOR  = 6'b100111;
    localparam logic [5:0] OP_SLT  = 6'b101010;
    localparam logic [5:0] OP_SLTU = 6'b101011;
    localparam logic [5:0] OP_CLO  = 6'b011100;
    localparam logic [5:0] OP_CLZ  = 6'b011101;
    localparam logic [5:0] OP_EQ   = 6'b011111;
    localparam logic [5:0] OP_GT   = 6'b001111;
    localparam logic [5:0] OP_PASS = 6'b111111;

    // Primary opcodes (IR[31:26])
    localparam logic [5:0] OPC_RTYPE    = 6'b000000;
    localparam logic [5:0] OPC_SPECIAL2 = 6'b011100;
    localparam logic [5:0] OPC_J        = 6'b000010;
    localparam logic [5:0] OPC_JAL      = 6'b000011;
    localparam logic [5:0] OPC_BEQ      = 6'b000100;
    localparam logic [5:0] OPC_BNE      = 6'b000101;
    localparam logic [5:0] OPC_BLEZ     = 6'b000110;
    localparam logic [5:0] OPC_BGTZ     = 6'b000111;
    localparam logic [5:0] OPC_ADDI     = 6'b001000;
    localparam logic [5:0] OPC_ADDIU    = 6'b001001;
    localparam logic [5:0] OPC_SLTI     = 6'b001010;
    localparam logic [5:0] OPC_SLTIU    = 6'b001011;
    localparam logic [5:0] OPC_ANDI     = 6'b001100;
    localparam logic [5:0] OPC_ORI      = 6'b001101;
    localparam logic [5:0] OPC_XORI     = 6'b001110;
    localparam logic [5:0] OPC_LUI      = 6'b001111;
    localparam logic [5:0] OPC_LW       = 6'b100011;
    localparam logic [5:0] OPC_SW       = 6'b101011;

    // Function codes needing special handling (IR[5:0])
    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_SRA  = 6'b000011;
    localparam logic [5:0] FN_JR   = 6'b001000;
    localparam logic [5:0] FN_MOVZ = 6'b001010;
    localparam logic [5:0] FN_MOVN = 6'b001011;
    localparam logic [5:0] FN_CLZ  = 6'b100000;
    localparam logic [5:0] FN_CLO  = 6'b100001;

    // Datapath select encodings
    localparam logic [1:0] SRC_A_PC     = 2'd0;
    localparam logic [1:0] SRC_A_RS     = 2'd1;
    localparam logic [1:0] SRC_A_IMM_HI = 2'd2;
    localparam logic [1:0] SRC_A_SHAMT  = 2'd3;

    localparam logic [1:0] SRC_B_RT   = 2'd0;
    localparam logic [1:0] SRC_B_SEXT = 2'd1;
    localparam logic [1:0] SRC_B_ZEXT = 2'd2;
    localparam logic [1:0] SRC_B_FOUR = 2'd3;

    localparam logic [1:0] PC_SRC_ALU    = 2'd0;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
    localparam logic [1:0] PC_SRC_JUMP   = 2'd2;
    localparam logic [1:0] PC_SRC_RS     = 2'd3;

    localparam logic [1:0] REG_DST_RT  = 2'd0;
    localparam logic [1:0] REG_DST_RD  = 2'd1;
    localparam logic [1:0] REG_DST_R31 = 2'd2;

endpackage

// File: rtl/mips_alu_op_decode.sv
// Combinational instruction decoder for the MIPS control unit.
// Ports:
//   opcode, funct  in  IR[31:26], IR[5:0]
//   operation      out ALU function code used in EXEC/BRANCH
//   legal          out instruction is implemented
//   src_a, src_b   out ALU operand selects used in EXEC/BRANCH
module mips_alu_op_decode
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [5:0] operation,
    output logic       legal,
    output logic [1:0] src_a,
    output logic [1:0] src_b
);

    always_comb begin
        operation = OP_ADDU;
        legal     = 1'b0;
        src_a     = SRC_A_RS;
        src_b     = SRC_B_RT;
        case (opcode)
            OPC_RTYPE: begin
                case (funct)
                    6'b100000, 6'b100001, 6'b100010, 6'b100011,
                    6'b100100, 6'b100101, 6'b100110, 6'b100111,
                    6'b101010, 6'b101011, 6'b000100, 6'b000110,
                    6'b000111, FN_MOVZ, FN_MOVN: begin
                        operation = funct;
                        legal     = 1'b1;
                    end
                    FN_SLL, FN_SRL, FN_SRA: begin
                        operation = funct;
                        legal     = 1'b1;
                        src_a     = SRC_A_SHAMT;
                    end
                    FN_JR:   legal = 1'b1;
                    default: legal = 1'b0;
                endcase
            end
            OPC_SPECIAL2: begin
                case (funct)
                    FN_CLO: begin
                        operation = OP_CLO;
                        legal     = 1'b1;
                    end
                    FN_CLZ: begin
                        operation = OP_CLZ;
                        legal     = 1'b1;
                    end
                    default: legal = 1'b0;
                endcase
            end
            OPC_ADDI: begin
                operation = OP_ADD;
                src_b     = SRC_B_SEXT;
                legal     = 1'b1;
            end
            OPC_ADDIU, OPC_LW, OPC_SW: begin
                operation = OP_ADDU;
                src_b     = SRC_B_SEXT;
                legal     = 1'b1;
            end
            OPC_SLTI: begin
                operation = OP_SLT;
                src_b     = SRC_B_SEXT;
                legal     = 1'b1;
            end
            OPC_SLTIU: begin
                operation = OP_SLTU;
                src_b     = SRC_B_SEXT;
                legal     = 1'b1;
            end
            OPC_ANDI: begin
                operation = OP_AND;
                src_b     = SRC_B_ZEXT;
                legal     = 1'b1;
            end
            OPC_ORI: begin
                operation = OP_OR;
                src_b     = SRC_B_ZEXT;
                legal     = 1'b1;
            end
            OPC_XORI: begin
                operation = OP_XOR;
                src_b     = SRC_B_ZEXT;
                legal     = 1'b1;
            end
            OPC_LUI: begin
                // ALU passes operand a, which is already {imm, 16'b0}
                operation = OP_PASS;
                src_a     = SRC_A_IMM_HI;
                legal     = 1'b1;
            end
            OPC_BEQ, OPC_BNE: begin
                operation = OP_EQ;
                legal     = 1'b1;
            end
            // rt is $0 for these, so the compare is against zero
            OPC_BLEZ, OPC_BGTZ: begin
                operation = OP_GT;
                legal     = 1'b1;
            end
            OPC_J, OPC_JAL: begin
                src_a = SRC_A_PC;
                legal = 1'b1;
            end
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/mips_control_fsm.sv
// Multicycle MIPS control unit. Sequences FETCH/DECODE/EXEC/MEM/WB and drives
// the ALU operation code, datapath selects and memory requests.
// Ports:
//   clk, reset            clock and asynchronous active-high reset
//   opcode, funct         instruction fields (valid from DECODE onward)
//   alu_zero, rt_zero     ALU zero flag, GPR[rt]==0
//   mem_ack               memory completes the current request
//   operation             ALU function code
//   alu_src_a, alu_src_b  ALU operand selects
//   mem_req, mem_we, iord memory request, write enable, address select
//   ir_write, pc_write    IR / PC load enables; pc_src selects the PC source
//   reg_write, reg_dst    GPR write enable and destination select
//   mem_to_reg            writeback from MDR instead of ALUOut
//   illegal               high while trapped
module mips_control_fsm
    import mips_ctrl_pkg::*;
#(
    parameter logic [3:0] RESET_STATE = 4'd0,
    parameter bit         TRAP_HOLD   = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       alu_zero,
    input  logic       rt_zero,
    input  logic       mem_ack,
    output logic [5:0] operation,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       mem_req,
    output logic       mem_we,
    output logic       iord,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       reg_write,
    output logic [1:0] reg_dst,
    output logic       mem_to_reg,
    output logic       illegal
);

    state_t     state_q, state_d;
    logic [5:0] dec_op;
    logic       dec_legal;
    logic [1:0] dec_src_a;
    logic [1:0] dec_src_b;
    logic       is_rtype;
    logic       branch_taken;
    logic       wb_enable;

    mips_alu_op_decode u_decode (
        .opcode    (opcode),
        .funct     (funct),
        .operation (dec_op),
        .legal     (dec_legal),
        .src_a     (dec_src_a),
        .src_b     (dec_src_b)
    );

    assign is_rtype = (opcode == OPC_RTYPE);

    always_comb begin
        case (opcode)
            OPC_BEQ, OPC_BLEZ: branch_taken = alu_zero;
            OPC_BNE, OPC_BGTZ: branch_taken = !alu_zero;
            default:           branch_taken = 1'b0;
        endcase
    end

    // Conditional moves suppress the register write when their condition fails
    assign wb_enable = !(is_rtype && (funct == FN_MOVZ) && !rt_zero) &&
                       !(is_rtype && (funct == FN_MOVN) && rt_zero);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= state_t'(RESET_STATE);
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        operation  = OP_ADDU;
        alu_src_a  = SRC_A_PC;
        alu_src_b  = SRC_B_RT;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = PC_SRC_ALU;
        reg_write  = 1'b0;
        reg_dst    = REG_DST_RT;
        mem_to_reg = 1'b0;
        illegal    = 1'b0;

        case (state_q)
            StFetch: begin
                mem_req   = 1'b1;
                alu_src_b = SRC_B_FOUR;
                if (mem_ack) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = StDecode;
                end
            end
            StDecode: begin
                // Branch target PC + (sext(imm) << 2) goes to ALUOut; the word
                // shift is applied on the sign-extended path in the datapath.
                alu_src_b = SRC_B_SEXT;
                if (!dec_legal) begin
                    state_d = StTrap;
                end else begin
                    case (opcode)
                        OPC_BEQ, OPC_BNE, OPC_BLEZ, OPC_BGTZ: state_d = StBranch;
                        OPC_J, OPC_JAL:                       state_d = StJump;
                        OPC_RTYPE: state_d = (funct == FN_JR) ? StJump : StExec;
                        default:                              state_d = StExec;
                    endcase
                end
            end
            StExec: begin
                operation = dec_op;
                alu_src_a = dec_src_a;
                alu_src_b = dec_src_b;
                if (opcode == OPC_LW) begin
                    state_d = StMemRd;
                end else if (opcode == OPC_SW) begin
                    state_d = StMemWr;
                end else begin
                    state_d = StWbAlu;
                end
            end
            StMemRd, StMemWr: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                mem_we  = (state_q == StMemWr);
                if (mem_ack) begin
                    state_d = (state_q == StMemWr) ? StFetch : StWbMem;
                end
            end
            StWbMem: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_d    = StFetch;
            end
            StWbAlu: begin
                reg_write = wb_enable;
                reg_dst   = is_rtype ? REG_DST_RD : REG_DST_RT;
                state_d   = StFetch;
            end
            StBranch: begin
                operation = dec_op;
                alu_src_a = dec_src_a;
                alu_src_b = dec_src_b;
                if (branch_taken) begin
                    pc_write = 1'b1;
                    pc_src   = PC_SRC_ALUOUT;
                end
                state_d = StFetch;
            end
            StJump: begin
                pc_write = 1'b1;
                pc_src   = is_rtype ? PC_SRC_RS : PC_SRC_JUMP;
                // JAL links PC (already PC+4) into r31
                if (opcode == OPC_JAL) begin
                    reg_write = 1'b1;
                    reg_dst   = REG_DST_R31;
                end
                state_d = StFetch;
            end
            StTrap: begin
                illegal = 1'b1;
                state_d = TRAP_HOLD ? StTrap : StFetch;
            end
            default: state_d = StFetch;
        endcase

        // Outputs collapse as soon as reset rises, without waiting for a clock
        if (reset) begin
            operation  = OP_ADDU;
            alu_src_a  = SRC_A_PC;
            alu_src_b  = SRC_B_RT;
            mem_req    = 1'b0;
            mem_we     = 1'b0;
            iord       = 1'b0;
            ir_write   = 1'b0;
            pc_write   = 1'b0;
            pc_src     = PC_SRC_ALU;
            reg_write  = 1'b0;
            reg_dst    = REG_DST_RT;
            mem_to_reg = 1'b0;
            illegal    = 1'b0;
        end
    end

endmodule

// File: tb/tb_mips_control_fsm.sv
// Self-checking bench for mips_control_fsm: directed instructions followed by
// randomized instructions, flags and memory wait states, each checked cycle by
// cycle against an instruction-level reference model.
module tb_mips_control_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode, funct;
    logic       alu_zero, rt_zero, mem_ack;
    logic [5:0] operation;
    logic [1:0] alu_src_a, alu_src_b, pc_src, reg_dst;
    logic       mem_req, mem_we, iord, ir_write, pc_write, reg_write, mem_to_reg, illegal;

    int errors = 0;
    int checks = 0;

    localparam int KTRAP   = 0;
    localparam int KALU    = 1;
    localparam int KLOAD   = 2;
    localparam int KSTORE  = 3;
    localparam int KBRANCH = 4;
    localparam int KJUMP   = 5;

    localparam logic [5:0] ADDU = 6'b100001;

    logic [5:0] opc_pool [19];
    logic [5:0] fn_pool  [19];

    always #5 clk = ~clk;

    mips_control_fsm #(
        .RESET_STATE (4'd0),
        .TRAP_HOLD   (1'b1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .funct      (funct),
        .alu_zero   (alu_zero),
        .rt_zero    (rt_zero),
        .mem_ack    (mem_ack),
        .operation  (operation),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .iord       (iord),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .pc_src     (pc_src),
        .reg_write  (reg_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .illegal    (illegal)
    );

    // {operation, src_a, src_b, mem_req, mem_we, iord, ir_write, pc_write, pc_src,
    //  reg_write, reg_dst, mem_to_reg, illegal}
    logic [21:0] obs;
    assign obs = {operation, alu_src_a, alu_src_b, mem_req, mem_we, iord, ir_write, pc_write,
                  pc_src, reg_write, reg_dst, mem_to_reg, illegal};

    function automatic logic [21:0] pack(input logic [5:0] op, input logic [1:0] sa,
                                         input logic [1:0] sb, input logic mreq,
                                         input logic mwe, input logic ird, input logic irw,
                                         input logic pcw, input logic [1:0] pcs,
                                         input logic rw, input logic [1:0] rd,
                                         input logic m2r, input logic ill);
        return {op, sa, sb, mreq, mwe, ird, irw, pcw, pcs, rw, rd, m2r, ill};
    endfunction

    // Instruction class from the ISA tables
    function automatic int model_kind(input logic [5:0] opc, input logic [5:0] fn);
        if (opc == 6'b000000) begin
            if (fn == 6'b001000) return KJUMP;
            if (fn inside {[6'b100000:6'b100111], 6'b101010, 6'b101011, 6'b000000, 6'b000010,
                           6'b000011, 6'b000100, 6'b000110, 6'b000111, 6'b001010, 6'b001011})
                return KALU;
            return KTRAP;
        end
        if (opc == 6'b011100) return (fn inside {6'b100000, 6'b100001}) ? KALU : KTRAP;
        if (opc inside {6'b000010, 6'b000011}) return KJUMP;
        if (opc inside {[6'b000100:6'b000111]}) return KBRANCH;
        if (opc inside {[6'b001000:6'b001111]}) return KALU;
        if (opc == 6'b100011) return KLOAD;
        if (opc == 6'b101011) return KSTORE;
        return KTRAP;
    endfunction

    // Expected EXEC-cycle outputs
    function automatic logic [21:0] model_exec(input logic [5:0] opc, input logic [5:0] fn);
        logic [5:0] itab [8];
        logic [5:0] op;
        logic [1:0] sa, sb;
        itab = '{6'b100000, 6'b100001, 6'b101010, 6'b101011,
                 6'b100100, 6'b100101, 6'b100110, 6'b111111};
        op = ADDU;
        sa = 2'd1;
        sb = 2'd0;
        if (opc == 6'b000000) begin
            op = fn;
            if (fn inside {6'b000000, 6'b000010, 6'b000011}) sa = 2'd3;
        end else if (opc == 6'b011100) begin
            op = (fn == 6'b100001) ? 6'b011100 : 6'b011101;
        end else if (opc == 6'b100011 || opc == 6'b101011) begin
            sb = 2'd1;
        end else begin
            op = itab[opc[2:0]];
            sb = opc[2] ? 2'd2 : 2'd1;
            if (opc == 6'b001111) begin
                sa = 2'd2;
                sb = 2'd0;
            end
        end
        return pack(op, sa, sb, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0);
    endfunction

    task automatic check(input string tag, input logic [21:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_ack();
        mem_ack = 1'($urandom_range(0, 1));
    endtask

    task automatic do_reset(input string name);
        mem_ack = 1'b1;
        reset   = 1'b1;
        #1;
        check({name, " reset outputs"},
              pack(ADDU, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0));
        @(posedge clk);
        #1;
        reset   = 1'b0;
        mem_ack = 1'b0;
    endtask

    // Entered and left at posedge+1 with the DUT in FETCH
    task automatic run_instr(input string name, input logic [5:0] opc, input logic [5:0] fn,
                             input logic az, input logic rz, input int fwait, input int mwait);
        int   kind;
        logic st, taken, rw;
        kind     = model_kind(opc, fn);
        opcode   = opc;
        funct    = fn;
        alu_zero = az;
        rt_zero  = rz;
        for (int i = 0; i < fwait; i++) begin
            mem_ack = 1'b0;
            #1;
            check({name, " fetch wait"}, pack(ADDU, 2'd0, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                                              2'd0, 1'b0, 2'd0, 1'b0, 1'b0));
            tick();
        end
        mem_ack = 1'b1;
        #1;
        check({name, " fetch ack"}, pack(ADDU, 2'd0, 2'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1,
                                         2'd0, 1'b0, 2'd0, 1'b0, 1'b0));
        tick();
        rand_ack();
        #1;
        check({name, " decode"}, pack(ADDU, 2'd0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                      2'd0, 1'b0, 2'd0, 1'b0, 1'b0));
        tick();
        case (kind)
            KTRAP: begin
                for (int i = 0; i < 3; i++) begin
                    rand_ack();
                    #1;
                    check({name, " trap"}, pack(ADDU, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                                2'd0, 1'b0, 2'd0, 1'b0, 1'b1));
                    tick();
                end
                do_reset(name);
            end
            KALU, KLOAD, KSTORE: begin
                rand_ack();
                #1;
                check({name, " exec"}, model_exec(opc, fn));
                tick();
                if (kind == KALU) begin
                    rw = !(opc == 6'b000000 && fn == 6'b001010 && !rz) &&
                         !(opc == 6'b000000 && fn == 6'b001011 && rz);
                    rand_ack();
                    #1;
                    check({name, " wb alu"}, pack(ADDU, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                                  2'd0, rw, (opc == 6'b000000) ? 2'd1 : 2'd0,
                                                  1'b0, 1'b0));
                    tick();
                end else begin
                    st = (kind == KSTORE);
                    for (int i = 0; i <= mwait; i++) begin
                        mem_ack = (i == mwait);
                        #1;
                        check({name, " mem"}, pack(ADDU, 2'd0, 2'd0, 1'b1, st, 1'b1, 1'b0, 1'b0,
                                                   2'd0, 1'b0, 2'd0, 1'b0, 1'b0));
                        tick();
                    end
                    if (!st) begin
                        rand_ack();
                        #1;
                        check({name, " wb mem"}, pack(ADDU, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0,
                                                      1'b0, 2'd0, 1'b1, 2'd0, 1'b1, 1'b0));
                        tick();
                    end
                end
            end
            KBRANCH: begin
                taken = (opc == 6'b000100 || opc == 6'b000110) ? az : !az;
                rand_ack();
                #1;
                check({name, " branch"}, pack(opc[1] ? 6'b001111 : 6'b011111, 2'd1, 2'd0, 1'b0,
                                              1'b0, 1'b0, 1'b0, taken, taken ? 2'd1 : 2'd0,
                                              1'b0, 2'd0, 1'b0, 1'b0));
                tick();
            end
            default: begin
                rand_ack();
                #1;
                check({name, " jump"}, pack(ADDU, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                                            (opc == 6'b000000) ? 2'd3 : 2'd2,
                                            opc == 6'b000011,
                                            (opc == 6'b000011) ? 2'd2 : 2'd0, 1'b0, 1'b0));
                tick();
            end
        endcase
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d",
                 errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] opc, fn;
        opc_pool = '{6'h00, 6'h00, 6'h1c, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07, 6'h08,
                     6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h0f, 6'h23, 6'h2b};
        fn_pool  = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b,
                     6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08, 6'h0a, 6'h0b};
        reset    = 1'b1;
        opcode   = 6'd0;
        funct    = 6'd0;
        alu_zero = 1'b0;
        rt_zero  = 1'b0;
        mem_ack  = 1'b0;
        #1;
        check("reset state", pack(ADDU, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0,
                                  2'd0, 1'b0, 1'b0));
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // IR = 0x01095020: add $10, $8, $9
        run_instr("ADD", 6'b000000, 6'b100000, 1'b0, 1'b0, 0, 0);
        run_instr("LW", 6'b100011, 6'b000000, 1'b0, 1'b0, 0, 2);
        run_instr("SW", 6'b101011, 6'b000000, 1'b0, 1'b0, 1, 1);
        run_instr("BEQ z=1", 6'b000100, 6'b000000, 1'b1, 1'b0, 0, 0);
        run_instr("BNE z=1", 6'b000101, 6'b000000, 1'b1, 1'b0, 0, 0);
        run_instr("CLO", 6'b011100, 6'b100001, 1'b0, 1'b0, 0, 0);
        run_instr("MOVZ rt!=0", 6'b000000, 6'b001010, 1'b0, 1'b0, 0, 0);
        run_instr("JAL", 6'b000011, 6'b000000, 1'b0, 1'b0, 0, 0);

        // Reset while FETCH is waiting on memory
        mem_ack = 1'b0;
        #1;
        check("mid-fetch before reset", pack(ADDU, 2'd0, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                                             2'd0, 1'b0, 2'd0, 1'b0, 1'b0));
        do_reset("mid-fetch");

        run_instr("illegal opcode", 6'b111111, 6'b000000, 1'b0, 1'b0, 0, 0);

        for (int n = 0; n < 80; n++) begin
            opc = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(0, 63))
                                              : opc_pool[$urandom_range(0, 18)];
            fn  = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(0, 63))
                                              : fn_pool[$urandom_range(0, 18)];
            if (opc == 6'b011100 && $urandom_range(0, 1) == 1) fn = 6'b100000;
            run_instr($sformatf("rand%0d opc=%b fn=%b", n, opc, fn), opc, fn,
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      $urandom_range(0, 2), $urandom_range(0, 2));
        end

        mem_ack = 1'b0;
        #1;
        check("final fetch", pack(ADDU, 2'd0, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0,
                                  2'd0, 1'b0, 1'b0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
